// File: rtl/boss_stage_ctrl.sv
// Boss stage sequencer: IDLE -> INTRO -> FIGHT -> OUTRO_WIN/OUTRO_LOSE -> DONE.
// Optional feature macro: BOSS_TIME_BONUS_EN adds a fast-win time bonus to the win score.
module boss_stage_ctrl #(
  parameter int INTRO_FRAMES    = 60,
  parameter int OUTRO_FRAMES    = 30,
  parameter int FRAME_CNT_WIDTH = 12,
  parameter int BONUS_WIDTH     = 8,
  parameter int WIN_BONUS       = 100,
  parameter int TIME_BONUS_MAX  = 64
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       stage_start,
  input  logic                       boss_dead,
  input  logic                       player_dead,
  output logic                       boss_enable,
  output logic                       boss_clear,
  output logic                       stage_active,
  output logic                       stage_won,
  output logic                       stage_lost,
  output logic                       stage_done,
  output logic [FRAME_CNT_WIDTH-1:0] fight_frames,
  output logic [BONUS_WIDTH-1:0]     bonus_score,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INTRO      = 3'd1,
    S_FIGHT      = 3'd2,
    S_OUTRO_WIN  = 3'd3,
    S_OUTRO_LOSE = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam int CNT_MAX = (INTRO_FRAMES > OUTRO_FRAMES) ? INTRO_FRAMES : OUTRO_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INTRO_LAST = CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0] OUTRO_LAST = CNT_W'(OUTRO_FRAMES - 1);
  localparam logic [31:0] BONUS_MAX = 32'((64'd1 << BONUS_WIDTH) - 64'd1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAMES_SAT = '1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   frame_cnt;
  logic               start_req;
  logic               state_change;
  logic               in_outro;
  logic [BONUS_WIDTH-1:0] bonus_next;

  assign start_req    = (state == S_IDLE || state == S_DONE) && stage_start;
  assign state_change = (state_next != state);
  assign in_outro     = (state == S_OUTRO_WIN) || (state == S_OUTRO_LOSE);
  assign dbg_state    = state;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; boss_dead has priority over player_dead in FIGHT
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (stage_start) state_next = S_INTRO;
      S_INTRO:        if (startOfFrame && frame_cnt == INTRO_LAST) state_next = S_FIGHT;
      S_FIGHT: begin
        if (boss_dead)        state_next = S_OUTRO_WIN;
        else if (player_dead) state_next = S_OUTRO_LOSE;
      end
      S_OUTRO_WIN, S_OUTRO_LOSE:
        if (startOfFrame && frame_cnt == OUTRO_LAST) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Level outputs decoded from state; the boss keeps running in OUTRO_WIN to finish its death fade
  always_comb begin
    boss_enable  = 1'b0;
    stage_active = 1'b0;
    stage_done   = 1'b0;
    unique case (state)
      S_INTRO:      stage_active = 1'b1;
      S_FIGHT:      begin stage_active = 1'b1; boss_enable = 1'b1; end
      S_OUTRO_WIN:  begin stage_active = 1'b1; boss_enable = 1'b1; end
      S_OUTRO_LOSE: stage_active = 1'b1;
      S_DONE:       stage_done = 1'b1;
      default:      ;
    endcase
  end

  // Shared INTRO/OUTRO frame counter; a frame pulse on a state-change cycle belongs to the old state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                      frame_cnt <= '0;
    else if (state_change)                            frame_cnt <= '0;
    else if (startOfFrame && (state == S_INTRO || in_outro)) frame_cnt <= frame_cnt + 1'b1;
  end

  // Pulse outputs are single-cycle strobes with no handshake: the consumer samples them every cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      boss_clear <= 1'b0;
      stage_won  <= 1'b0;
      stage_lost <= 1'b0;
    end else begin
      boss_clear <= start_req;
      stage_won  <= (state == S_FIGHT) && boss_dead;
      stage_lost <= (state == S_FIGHT) && !boss_dead && player_dead;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                   fight_frames <= '0;
    else if (start_req)                            fight_frames <= '0;
    else if (state == S_FIGHT && startOfFrame && fight_frames != FRAMES_SAT)
      fight_frames <= fight_frames + 1'b1;
  end

`ifdef BOSS_TIME_BONUS_EN
  // Faster wins earn up to TIME_BONUS_MAX extra, one point lost per 64 fight frames
  logic [31:0] time_units, time_extra, bonus_sum;
  always_comb begin
    time_units = 32'(fight_frames >> 6);
    time_extra = (time_units < 32'(TIME_BONUS_MAX)) ? (32'(TIME_BONUS_MAX) - time_units) : 32'd0;
    bonus_sum  = 32'(WIN_BONUS) + time_extra;
    bonus_next = (bonus_sum > BONUS_MAX) ? BONUS_MAX[BONUS_WIDTH-1:0] : bonus_sum[BONUS_WIDTH-1:0];
  end
`else
  logic [31:0] bonus_sum;
  always_comb begin
    bonus_sum  = 32'(WIN_BONUS);
    bonus_next = (bonus_sum > BONUS_MAX) ? BONUS_MAX[BONUS_WIDTH-1:0] : bonus_sum[BONUS_WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                           bonus_score <= '0;
    else if (start_req)                    bonus_score <= '0;
    else if (state == S_FIGHT && boss_dead) bonus_score <= bonus_next;
  end

endmodule

// File: tb/tb_boss_stage_ctrl.sv
// Scoreboard bench for boss_stage_ctrl; expected bonus follows BOSS_TIME_BONUS_EN when defined.
module tb_boss_stage_ctrl;
  localparam int W = 24;
  localparam logic [3:0] EV_CLEAR = 4'b0001;
  localparam logic [3:0] EV_WON   = 4'b0010;
  localparam logic [3:0] EV_LOST  = 4'b0100;
  localparam logic [3:0] EV_DONE  = 4'b1000;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        stage_start = 1'b0;
  logic        boss_dead = 1'b0;
  logic        player_dead = 1'b0;
  logic        boss_enable, boss_clear, stage_active, stage_won, stage_lost, stage_done;
  logic [11:0] fight_frames;
  logic [7:0]  bonus_score;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  boss_stage_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .stage_start(stage_start),
    .boss_dead(boss_dead), .player_dead(player_dead), .boss_enable(boss_enable),
    .boss_clear(boss_clear), .stage_active(stage_active), .stage_won(stage_won),
    .stage_lost(stage_lost), .stage_done(stage_done), .fight_frames(fight_frames),
    .bonus_score(bonus_score), .dbg_state(dbg_state)
  );

  // Clock
  initial forever #5 clk = ~clk;

  function automatic logic [7:0] model_bonus(input int frames);
    int sum;
    sum = 100;
`ifdef BOSS_TIME_BONUS_EN
    if ((frames / 64) < 64) sum = sum + (64 - frames / 64);
`endif
    if (sum > 255) sum = 255;
    return 8'(sum);
  endfunction

  function automatic logic [W-1:0] rec(input logic [3:0] ev, input int frames, input logic [7:0] bonus);
    return {ev, 12'(frames), bonus};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic start_stage();
    exp_q.push_back(rec(EV_CLEAR, 0, 8'd0));
    stage_start = 1'b1;
    tick();
    stage_start = 1'b0;
  endtask

  task automatic monitor();
    logic       prev_done;
    logic [3:0] ev;
    logic [W-1:0] act, exp;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      ev = {stage_done & ~prev_done, stage_lost, stage_won, boss_clear};
      if (ev != 4'b0) begin
        act = {ev, fight_frames, bonus_score};
        if (exp_q.size() == 0) check("unexpected_event", 32'(act), 32'd0);
        else begin
          exp = exp_q.pop_front();
          check("event", 32'(act), 32'(exp));
        end
      end
      prev_done = stage_done;
    end
  endtask

  task automatic stimulus();
    tick(3);
    resetN = 1'b1;
    tick();
    check("reset_outputs", 32'({boss_enable, boss_clear, stage_active, stage_won, stage_lost,
                                stage_done, fight_frames, bonus_score}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // Start and intro: boss frozen for 60 frames
    start_stage();
    check("intro_active", 32'({stage_active, boss_enable}), 32'b10);
    frames(59);
    check("intro_59_frozen", 32'(boss_enable), 32'd0);
    frames(1);
    check("fight_enable", 32'(boss_enable), 32'd1);
    check("fight_frames_start", 32'(fight_frames), 32'd0);

    // Win after 100 fight frames
    frames(100);
    check("fight_frames_100", 32'(fight_frames), 32'd100);
    exp_q.push_back(rec(EV_WON, 100, model_bonus(100)));
    boss_dead = 1'b1;
    tick(2);
    check("outro_win_enable", 32'(boss_enable), 32'd1);
    frames(29);
    check("outro_win_not_done", 32'(stage_done), 32'd0);
    exp_q.push_back(rec(EV_DONE, 100, model_bonus(100)));
    frames(1);
    check("done_after_win", 32'({stage_done, stage_active, boss_enable}), 32'b100);
    boss_dead = 1'b0;

    // Loss after 10 fight frames
    start_stage();
    frames(60);
    frames(10);
    exp_q.push_back(rec(EV_LOST, 10, 8'd0));
    player_dead = 1'b1;
    tick(2);
    check("outro_lose_enable", 32'(boss_enable), 32'd0);
    check("lose_bonus", 32'(bonus_score), 32'd0);
    frames(29);
    check("outro_lose_not_done", 32'(stage_done), 32'd0);
    exp_q.push_back(rec(EV_DONE, 10, 8'd0));
    frames(1);
    check("done_after_loss", 32'(stage_done), 32'd1);
    player_dead = 1'b0;

    // Ignored restart during FIGHT, then simultaneous deaths, then reset in OUTRO_WIN
    start_stage();
    frames(60);
    frames(3);
    stage_start = 1'b1;
    tick();
    stage_start = 1'b0;
    tick();
    check("restart_ignored_state", 32'(dbg_state), 32'd2);
    check("restart_ignored_frames", 32'(fight_frames), 32'd3);
    exp_q.push_back(rec(EV_WON, 3, model_bonus(3)));
    boss_dead = 1'b1;
    player_dead = 1'b1;
    tick(2);
    frames(5);
    check("outro_win_state", 32'(dbg_state), 32'd3);
    #2 resetN = 1'b0;
    #1 check("async_reset_outputs", 32'({boss_enable, boss_clear, stage_active, stage_won,
                                         stage_lost, stage_done, fight_frames, bonus_score}), 32'd0);
    check("async_reset_state", 32'(dbg_state), 32'd0);
    boss_dead = 1'b0;
    player_dead = 1'b0;
    tick(3);
    resetN = 1'b1;
    tick();

    // Saturating fight counter over 5000 frames
    start_stage();
    frames(60);
    frames(5000);
    check("fight_frames_sat", 32'(fight_frames), 32'd4095);
    exp_q.push_back(rec(EV_WON, 4095, model_bonus(4095)));
    boss_dead = 1'b1;
    tick(2);
    exp_q.push_back(rec(EV_DONE, 4095, model_bonus(4095)));
    frames(30);
    boss_dead = 1'b0;
    tick(2);
  endtask

  initial begin
    fork
      stimulus();
      monitor();
    join_any
    disable fork;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
